// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative square-root unit.
// Holds the FSM encoding, iteration count and K legality rules.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int K_MIN = 1;
  localparam int K_MID = 2;
  localparam int K_MAX = 4;

  function automatic int iter_count(int n, int k);
    return n / k;
  endfunction

  function automatic bit k_legal(int n, int k);
    return (k == K_MIN || k == K_MID || k == K_MAX)
        && (n % k == 0);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root step: resolves root bit i
// and subtracts the trial term from the running remainder.
module sqrt_step #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   r,
  input  logic [W-1:0]   i,
  output logic [2*N-1:0] a_nx,
  output logic [N-1:0]   r_nx
);

  localparam logic [2*N-1:0] ONE_A = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   ONE_R = {{(N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] rf;
  logic           ge;

  always_comb begin
    rf   = (({{N{1'b0}}, r} << 1) + (ONE_A << i)) << i;
    ge   = (a >= rf);
    a_nx = ge ? (a - rf) : a;
    r_nx = ge ? (r | (ONE_R << i)) : r;
  end

endmodule

// File: rtl/sqrt_iter_hs.sv
// Iterative integer square root, K root bits per cycle,
// valid/ready on both sides, optional round-to-nearest.
module sqrt_iter_hs
  import sqrt_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic           rnd,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   root,
  output logic [N:0]     remainder,
  output logic           sat
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam int ITERS = iter_count(N, K);
  localparam logic [W-1:0] I_TOP  = W'(ITERS * K - 1);
  localparam logic [W-1:0] I_LAST = W'(K - 1);
  localparam logic [W-1:0] I_STEP = W'(K);

  if (!k_legal(N, K)) begin : g_bad_k
    $error("sqrt_iter_hs: K must be 1, 2 or 4 and divide N");
  end

  state_t         state, state_nx;
  logic [2*N-1:0] acc;
  logic [N-1:0]   r;
  logic [W-1:0]   idx;
  logic           rnd_q;

  logic [2*N-1:0] ca [K+1];
  logic [N-1:0]   cr [K+1];

  assign ca[0] = acc;
  assign cr[0] = r;

  for (genvar j = 0; j < K; j++) begin : g_step
    logic [W-1:0] sidx;
    assign sidx = idx - W'(j);
    sqrt_step #(.N(N), .W(W)) u_step (
      .a    (ca[j]),
      .r    (cr[j]),
      .i    (sidx),
      .a_nx (ca[j+1]),
      .r_nx (cr[j+1])
    );
  end

  logic           last;
  logic           accept;
  logic [N-1:0]   fr;
  logic           round_up;
  logic [N-1:0]   root_nx;
  logic           sat_nx;

  assign last   = (idx == I_LAST);
  assign accept = (state == IDLE) && in_valid && !flush;
  assign fr     = cr[K];

  // Round up when the floor remainder exceeds r, i.e. a >= r^2 + r + 1.
  always_comb begin
    round_up = rnd_q && (ca[K] > {{N{1'b0}}, fr});
    sat_nx   = round_up && (&fr);
    root_nx  = (round_up && !(&fr))
             ? fr + {{(N-1){1'b0}}, 1'b1}
             : fr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid)  state_nx = CALC;
        CALC:    if (last)      state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default:                state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      r         <= '0;
      idx       <= '0;
      rnd_q     <= 1'b0;
      root      <= '0;
      remainder <= '0;
      sat       <= 1'b0;
    end else if (accept) begin
      acc   <= a;
      r     <= '0;
      idx   <= I_TOP;
      rnd_q <= rnd;
    end else if (state == CALC && !flush) begin
      acc <= ca[K];
      r   <= cr[K];
      idx <= idx - I_STEP;
      if (last) begin
        root      <= root_nx;
        remainder <= ca[K][N:0];
        sat       <= sat_nx;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sqrt_iter_hs.sv
// Bench for sqrt_iter_hs: K=1 and K=4 instances checked
// against a binary-search square-root model via a scoreboard.
module tb_sqrt_iter_hs;

  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] root;
    logic [N:0]   rem;
    logic         sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]     in_valid;
  logic [1:0]     rnd;
  logic [1:0]     flush;
  logic [1:0]     out_ready;
  logic [2*N-1:0] a [2];

  logic           in_ready_s  [2];
  logic           out_valid_s [2];
  logic           sat_s       [2];
  logic [N-1:0]   root_s      [2];
  logic [N:0]     rem_s       [2];

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sqrt_iter_hs #(.N(N), .K(1)) dut_k1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready_s[0]),
    .a         (a[0]),
    .rnd       (rnd[0]),
    .flush     (flush[0]),
    .out_valid (out_valid_s[0]),
    .out_ready (out_ready[0]),
    .root      (root_s[0]),
    .remainder (rem_s[0]),
    .sat       (sat_s[0])
  );

  sqrt_iter_hs #(.N(N), .K(4)) dut_k4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready_s[1]),
    .a         (a[1]),
    .rnd       (rnd[1]),
    .flush     (flush[1]),
    .out_valid (out_valid_s[1]),
    .out_ready (out_ready[1]),
    .root      (root_s[1]),
    .remainder (rem_s[1]),
    .sat       (sat_s[1])
  );

  function automatic exp_t model(logic [31:0] v, logic rn);
    exp_t e;
    longint unsigned lo, hi, mid, rm;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    rm = longint'(v) - lo * lo;
    e.root = lo[15:0];
    e.rem  = rm[16:0];
    e.sat  = 1'b0;
    if (rn && rm > lo) begin
      if (lo == 65535) e.sat = 1'b1;
      else begin
        mid = lo + 1;
        e.root = mid[15:0];
      end
    end
    return e;
  endfunction

  task automatic send(int d, logic [31:0] v, logic rn, bit push);
    @(negedge clk);
    in_valid[d] = 1'b1;
    a[d] = v;
    rnd[d] = rn;
    tests++;
    if (in_ready_s[d] !== 1'b1) begin
      fails++;
      $display("FAIL send_in_ready d=%0d got %b want 1", d, in_ready_s[d]);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    if (push) begin
      if (d == 0) q0.push_back(model(v, rn));
      else        q1.push_back(model(v, rn));
    end
  endtask

  task automatic get(int d, int lat, int hold);
    int cnt;
    exp_t e;
    cnt = 0;
    while (out_valid_s[d] !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    tests++;
    if (out_valid_s[d] !== 1'b1) begin
      fails++;
      $display("FAIL out_valid_timeout d=%0d got 0 want 1", d);
      return;
    end
    tests++;
    if (cnt !== lat) begin
      fails++;
      $display("FAIL latency d=%0d got %0d want %0d", d, cnt, lat);
    end
    tests++;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      fails++;
      $display("FAIL scoreboard_empty d=%0d got 0 want >0", d);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    tests++;
    if (root_s[d] !== e.root) begin
      fails++;
      $display("FAIL root d=%0d got %h want %h", d, root_s[d], e.root);
    end
    tests++;
    if (rem_s[d] !== e.rem) begin
      fails++;
      $display("FAIL remainder d=%0d got %h want %h", d, rem_s[d], e.rem);
    end
    tests++;
    if (sat_s[d] !== e.sat) begin
      fails++;
      $display("FAIL sat d=%0d got %b want %b", d, sat_s[d], e.sat);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out_valid_s[d] !== 1'b1 || in_ready_s[d] !== 1'b0) begin
        fails++;
        $display("FAIL hold_hs d=%0d got v=%b r=%b want v=1 r=0",
                 d, out_valid_s[d], in_ready_s[d]);
      end
      tests++;
      if ({root_s[d], rem_s[d], sat_s[d]} !== {e.root, e.rem, e.sat}) begin
        fails++;
        $display("FAIL hold_stable d=%0d got %h/%h/%b want %h/%h/%b", d,
                 root_s[d], rem_s[d], sat_s[d], e.root, e.rem, e.sat);
      end
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    tests++;
    if (out_valid_s[d] !== 1'b0 || in_ready_s[d] !== 1'b1) begin
      fails++;
      $display("FAIL post_accept d=%0d got v=%b r=%b want v=0 r=1",
               d, out_valid_s[d], in_ready_s[d]);
    end
  endtask

  task automatic check_reset_vals(string tag);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({in_ready_s[d], out_valid_s[d], root_s[d], rem_s[d], sat_s[d]}
          !== {1'b1, 1'b0, 16'h0, 17'h0, 1'b0}) begin
        fails++;
        $display("FAIL %s d=%0d got r=%b v=%b root=%h rem=%h sat=%b want 1 0 0 0 0",
                 tag, d, in_ready_s[d], out_valid_s[d], root_s[d],
                 rem_s[d], sat_s[d]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset_state");
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_floor();
    send(0, 32'h0, 1'b0, 1'b1);
    get(0, 16, 0);
    send(0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    get(0, 16, 0);
    send(0, 32'd15, 1'b0, 1'b1);
    get(0, 16, 0);
  endtask

  task automatic test_round();
    send(0, 32'd8, 1'b1, 1'b1);
    get(0, 16, 0);
    send(0, 32'd6, 1'b1, 1'b1);
    get(0, 16, 0);
    send(0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    get(0, 16, 0);
    send(0, 32'hFFFE_0001, 1'b1, 1'b1);
    get(0, 16, 0);
  endtask

  task automatic test_k4();
    send(1, 32'd1000000, 1'b0, 1'b1);
    get(1, 4, 0);
    send(1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    get(1, 4, 0);
    for (int n = 0; n < 40; n++) begin
      send(1, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      get(1, 4, 0);
    end
  endtask

  task automatic test_back_pressure();
    send(0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    get(0, 16, 5);
  endtask

  task automatic test_flush();
    logic [N-1:0] pr;
    logic [N:0]   pm;
    logic         ps;
    int seen;
    pr = root_s[0];
    pm = rem_s[0];
    ps = sat_s[0];
    send(0, 32'd12345, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    tests++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle got r=%b v=%b want r=1 v=0",
               in_ready_s[0], out_valid_s[0]);
    end
    tests++;
    if ({root_s[0], rem_s[0], sat_s[0]} !== {pr, pm, ps}) begin
      fails++;
      $display("FAIL flush_keep got %h/%h/%b want %h/%h/%b",
               root_s[0], rem_s[0], sat_s[0], pr, pm, ps);
    end
    @(negedge clk);
    in_valid[0] = 1'b1;
    flush[0] = 1'b1;
    a[0] = 32'd100;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    flush[0] = 1'b0;
    tests++;
    if (in_ready_s[0] !== 1'b1) begin
      fails++;
      $display("FAIL flush_with_valid got in_ready=%b want 1", in_ready_s[0]);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid_s[0] === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL flush_no_result got %0d valid cycles want 0", seen);
    end
    send(0, 32'd49, 1'b0, 1'b1);
    get(0, 16, 0);
  endtask

  task automatic test_reset_mid();
    int cnt;
    send(0, 32'h1234_5678, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_calc");
    #1;
    rst_n = 1'b1;
    send(0, 32'h1234_5678, 1'b0, 1'b1);
    get(0, 16, 0);
    send(0, 32'd99, 1'b1, 1'b0);
    cnt = 0;
    while (out_valid_s[0] !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    tests++;
    if (root_s[0] !== 16'd10) begin
      fails++;
      $display("FAIL pre_reset_done got root=%h want 000a", root_s[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_done");
    #1;
    rst_n = 1'b1;
    send(0, 32'd1000, 1'b0, 1'b1);
    get(0, 16, 0);
  endtask

  initial begin
    in_valid  = '0;
    rnd       = '0;
    flush     = '0;
    out_ready = '0;
    a[0]      = '0;
    a[1]      = '0;
    test_reset();
    test_floor();
    test_round();
    test_k4();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_iter_hs.md
# sqrt_iter_hs

Parametrised iterative integer square-root unit with valid/ready handshakes on both sides. It resolves K root bits per clock, so latency trades against area. It offers floor or round-to-nearest per operation and a synchronous flush. It replaces the single-bit start/complete square-root core in the datapath and sits between streaming producers and consumers that need back-pressure.

## Interface
- N, 16: root width; input operand is 2N bits.
- K, 1: root bits resolved per cycle; legal values 1, 2, 4; N mod K must be 0 (elaboration error otherwise).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  unit can accept an operand
- a  in  2N  radicand, sampled on input handshake
- rnd  in  1  0 = floor, 1 = round-to-nearest; sampled with a
- flush  in  1  synchronous abort; returns to IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- root  out  N  result root
- remainder  out  N+1  a − floor_root²; always the floor remainder, even when rnd=1
- sat  out  1  rnd=1 rounding would overflow N bits; root saturated

## Operation
- Restoring algorithm on bit index i from N−1 down to 0.
  - ref = ((r<<1) + (1<<i)) << i, computed in 2N bits.
  - If A ≥ ref: r[i]=1 and A −= ref. Otherwise r[i]=0.
- K such steps are chained combinationally per cycle, each step seeing the previous step's r/A.
- States:
  - IDLE: in_ready=1. On in_valid, latch a into A, latch rnd, clear r, set i=N−1, go to CALC.
  - CALC: in_ready=0. Perform K steps per cycle and decrement i by K. After the step group covering i=0, register the outputs and go to DONE.
  - DONE: out_valid=1 with root, remainder and sat held stable. On out_ready, go to IDLE.
- Rounding is applied on entry to DONE.
  - rnd=0: root=r.
  - rnd=1 and A > r: root=r+1.
  - If r+1 would be 2^N, root stays all-ones and sat=1.
  - sat=0 whenever rnd=0.
- flush has priority over every other input in every state:
  - next state is IDLE, out_valid=0.
  - An in-progress or unconsumed result is discarded. root, remainder and sat keep their last values.
- Reset (any state, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - root=0, remainder=0, sat=0; internal A, r and i cleared.
- An in_valid arriving while not in IDLE is ignored, because in_ready=0 and the producer must hold it.

## Timing
- The input handshake edge is E0. out_valid rises after edge E0+N/K.
  - N=16, K=1: 16 cycles.
  - N=16, K=4: 4 cycles.
- Output handshake edge E1: out_valid falls and in_ready rises after E1. There is no same-cycle accept of a new operand on E1. Throughput is one operation per N/K+2 cycles.
- root, remainder and sat change only on the edge entering DONE, and never while out_valid=1.
- out_valid is independent of out_ready combinationally. in_ready is a registered state decode.
- flush asserted in the same cycle as in_valid in IDLE: the operand is not accepted.
- Reset deasserted mid-cycle: the first handshake is possible on the first clk edge after release.

## Structure
- Shared package sqrt_pkg holds:
  - the state encoding (IDLE, CALC, DONE);
  - a localparam helper for the iteration count N/K;
  - the legality check constants for K.
- Sub-module sqrt_step is a combinational single-bit restoring step.
  - Inputs: A (2N), r (N), i.
  - Outputs: next A, next r.
  - Instantiated K times in a generate chain.
- The top level holds the FSM, counter, operand registers, rounding and output registers.

## Test plan
- N=16, K=1, rnd=0:
  - a=0 → root=0, remainder=0.
  - a=0xFFFFFFFF → root=0xFFFF, remainder=0x1FFFE, sat=0; out_valid exactly 16 cycles after accept.
- Rounding:
  - a=8, rnd=1 → root=3, remainder=4.
  - a=6, rnd=1 → root=2, remainder=2.
  - a=0xFFFFFFFF, rnd=1 → root=0xFFFF, sat=1.
- K=4, N=16: a=1000000 → root=1000, remainder=0; out_valid 4 cycles after accept; random sweep against a floor-sqrt model.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0; accept on release, then in_ready=1 the next cycle.
- flush after 3 CALC cycles → IDLE next cycle, no out_valid. A new operand a=49 then yields root=7, remainder=0.
- rst_n low mid-CALC and in DONE → all outputs at reset values immediately; a clean operation follows.
